ifid_instr_buffer: RTL
======================

Name: ifid_instr_buffer

Overview:
- Decoupling buffer between the instruction fetch stage and the decode stage.
- Stores fetched instruction/PC_Next pairs in a small FIFO and presents the oldest pair to decode with a valid/ready handshake.
- Back-pressures fetch through a stall output, which is wired to the fetch stage's stall input.
- Drops all contents on a taken branch (flush), and blocks further fetch after a HALT has been captured.

Parameters:
- DEPTH, 2, number of entries; power of two, >= 2.
- NOP_INSTR, 16'h0800, instruction word driven to decode when the buffer is empty.
- HALT_OPCODE, 5'b00000, value of instruction[15:11] that identifies HALT.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- if_valid  input  1  fetch is presenting a valid instruction this cycle.
- if_instruction  input  16  fetched instruction word.
- if_pc_next  input  16  PC+2 associated with if_instruction.
- if_stall  output  1  buffer cannot accept; fetch must hold its PC.
- flush  input  1  taken branch/redirect resolved in EX/MEM; discard all entries.
- id_ready  input  1  decode accepts the head entry this cycle.
- id_valid  output  1  head entry is valid.
- id_instruction  output  16  head instruction, or NOP_INSTR when empty.
- id_pc_next  output  16  head PC_Next, or 16'h0000 when empty.
- occupancy  output  log2(DEPTH)+1  current number of stored entries.
- halt_seen  output  1  a HALT has been enqueued since the last reset or flush.

Behaviour:
- State:
  - Storage array of DEPTH x 32 bits.
  - Write pointer and read pointer, each log2(DEPTH) bits, wrapping modulo DEPTH.
  - Count register, 0..DEPTH.
  - halt_seen flag.
- Reset (rst=0, asynchronous):
  - Pointers = 0, count = 0, halt_seen = 0.
  - Storage contents don't-care.
  - Outputs during and after reset: id_valid=0, id_instruction=NOP_INSTR, id_pc_next=0, occupancy=0, if_stall=0.
  - Reset asserted mid-operation drops every entry immediately, without waiting for a clock edge.
- if_stall = (count == DEPTH) | halt_seen. Purely a function of registered state; no combinational path from if_valid or id_ready.
- enq = if_valid & ~if_stall & ~flush.
- deq = id_ready & (count != 0) & ~flush.
- On enq:
  - Write {if_pc_next, if_instruction} at the write pointer; write pointer +1 (wraps).
  - If if_instruction[15:11] == HALT_OPCODE, set halt_seen next cycle. The HALT itself is stored.
- On deq: read pointer +1 (wraps).
- Count update: count + enq - deq. Simultaneous enq and deq leaves count unchanged.
- Full and id_ready in the same cycle: the entry drains, but no enqueue happens that cycle because if_stall was already high. The stall drops the following cycle.
- Empty and if_valid: the entry is visible on id_* the next cycle (1-cycle latency). No bypass.
- Head outputs are combinational reads at the read pointer, masked to NOP_INSTR / 16'h0000 when count == 0.
- flush (highest priority after reset):
  - Next edge: pointers = 0, count = 0, halt_seen = 0.
  - Any enq or deq presented in the same cycle is ignored.
- halt_seen stays set until flush or reset. Entries already stored continue to drain normally while it is set.
- Writes to storage occur only on enq; storage is never written during flush.

Test Plan:
- Reset then idle: rst low for 2 cycles with if_valid=1 -> id_valid=0, id_instruction=16'h0800, occupancy=0. After release, first edge with if_valid=1, if_instruction=16'hC005, if_pc_next=16'h0002 -> next cycle id_valid=1, id_instruction=16'hC005, id_pc_next=16'h0002.
- Fill to full, id_ready=0, enqueue 16'h1111 then 16'h2222 -> occupancy=2, if_stall=1. A third if_valid with 16'h3333 is not stored. Head remains 16'h1111.
- Full with id_ready=1 and if_valid=1 (16'h3333) on the same cycle -> 16'h1111 drained, 16'h3333 not accepted, occupancy=1. Next cycle if_stall=0 and 16'h3333 is accepted; order 2222, 3333 preserved across the pointer wrap.
- Steady stream with id_ready=1 every cycle, 8 sequential instructions -> occupancy stays 1 after the first cycle, id_* outputs the words in order, if_stall never asserts.
- Flush while holding 2 entries, with if_valid=1 and id_ready=1 asserted the same cycle -> next cycle occupancy=0, id_valid=0, id_instruction=16'h0800. The concurrent input is not stored.
- HALT: enqueue 16'h0000 -> halt_seen=1 and if_stall=1 from the next cycle. The HALT is delivered to decode; later if_valid is ignored. A subsequent flush clears halt_seen, and if_stall returns to 0.

Source files
------------

// File: rtl/ifid_instr_buffer.sv
// IF/ID decoupling FIFO: holds fetched {pc_next, instruction} pairs, presents the oldest to
// decode with valid/ready, back-pressures fetch, and supports flush and HALT blocking.
module ifid_instr_buffer #(
  parameter int unsigned Depth      = 2,
  parameter logic [15:0] NopInstr   = 16'h0800,
  parameter logic [4:0]  HaltOpcode = 5'b00000
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       if_valid_i,
  input  logic [15:0]                if_instruction_i,
  input  logic [15:0]                if_pc_next_i,
  output logic                       if_stall_o,
  input  logic                       flush_i,
  input  logic                       id_ready_i,
  output logic                       id_valid_o,
  output logic [15:0]                id_instruction_o,
  output logic [15:0]                id_pc_next_o,
  output logic [$clog2(Depth):0]     occupancy_o,
  output logic                       halt_seen_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] CntFull = CntW'(Depth);

  logic [31:0]     mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            halt_q, halt_d;
  logic            enq, deq, empty;

  assign empty      = (count_q == '0);
  // Stall depends only on registered state, so fetch sees no comb path from decode.
  assign if_stall_o = (count_q == CntFull) | halt_q;
  assign enq        = if_valid_i & ~if_stall_o & ~flush_i;
  assign deq        = id_ready_i & ~empty & ~flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    halt_d   = halt_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      halt_d   = 1'b0;
    end else begin
      if (enq) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        if (if_instruction_i[15:11] == HaltOpcode) halt_d = 1'b1;
      end
      if (deq) rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({enq, deq})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      halt_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      halt_q   <= halt_d;
    end
  end

  // Storage needs no reset; empty masking hides stale contents.
  always_ff @(posedge clk_i) begin
    if (enq) mem_q[wr_ptr_q] <= {if_pc_next_i, if_instruction_i};
  end

  assign id_valid_o       = ~empty;
  assign id_instruction_o = empty ? NopInstr : mem_q[rd_ptr_q][15:0];
  assign id_pc_next_o     = empty ? 16'h0000 : mem_q[rd_ptr_q][31:16];
  assign occupancy_o      = count_q;
  assign halt_seen_o      = halt_q;

endmodule
